// File: rtl/icache.sv
// Direct-mapped read-only instruction cache: registered hit response to the
// fetch PC, whole-line refill from the memory controller on a miss.
module icache #(
  parameter int INDEX_WIDTH = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        rdy_in,
  input  logic        clr_in,
  input  logic [31:0] iu_to_ic_pc,
  output logic        ic_to_iu_rdy,
  output logic [31:0] ic_to_iu_inst,
  output logic        ic_to_mc_req,
  output logic [31:0] ic_to_mc_addr,
  input  logic        mc_to_ic_rdy,
  input  logic [31:0] mc_to_ic_data
);

  localparam int LINES = 1 << INDEX_WIDTH;
  localparam int TAG_W = 28 - INDEX_WIDTH;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    FETCH = 1'b1
  } state_t;

  state_t                   state_r, state_s;
  logic [1:0]               cnt_r, cnt_s;
  logic [31:4]              base_r, base_s;
  logic                     rdy_s;
  logic [31:0]              inst_s;
  logic                     req_s;
  logic [31:0]              addr_s;
  logic                     buf_we_s;
  logic                     fill_s;
  logic [1:0]               cnt_inc_s;

  logic [LINES-1:0]         valid_r;
  logic [TAG_W-1:0]         tag_r  [LINES];
  logic [31:0]              data_r [LINES][4];
  logic [31:0]              buf_r  [4];

  logic [1:0]               offset_s;
  logic [INDEX_WIDTH-1:0]   index_s;
  logic [TAG_W-1:0]         tag_s;
  logic [INDEX_WIDTH-1:0]   fill_idx_s;
  logic                     hit_s;
  logic [1:0]               pc_unused_s;

  assign offset_s    = iu_to_ic_pc[3:2];
  assign index_s     = iu_to_ic_pc[INDEX_WIDTH+3:4];
  assign tag_s       = iu_to_ic_pc[31:INDEX_WIDTH+4];
  assign pc_unused_s = iu_to_ic_pc[1:0];
  assign fill_idx_s  = base_r[INDEX_WIDTH+3:4];
  assign hit_s       = valid_r[index_s] && (tag_r[index_s] == tag_s);
  assign cnt_inc_s   = cnt_r + 2'd1;

  // Next-state and next-output computation for the lookup/refill FSM.
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    base_s   = base_r;
    rdy_s    = 1'b0;
    inst_s   = ic_to_iu_inst;
    req_s    = ic_to_mc_req;
    addr_s   = ic_to_mc_addr;
    buf_we_s = 1'b0;
    fill_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (hit_s) begin
          // A flush suppresses the response but the lookup itself still happens.
          rdy_s  = ~clr_in;
          inst_s = data_r[index_s][offset_s];
        end else begin
          base_s  = iu_to_ic_pc[31:4];
          cnt_s   = 2'd0;
          req_s   = 1'b1;
          addr_s  = {iu_to_ic_pc[31:4], 4'b0000};
          state_s = FETCH;
        end
      end
      FETCH: begin
        req_s = 1'b1;
        if (mc_to_ic_rdy) begin
          if (cnt_r == 2'd3) begin
            fill_s  = 1'b1;
            req_s   = 1'b0;
            cnt_s   = 2'd0;
            state_s = IDLE;
          end else begin
            buf_we_s = 1'b1;
            cnt_s    = cnt_inc_s;
            addr_s   = {base_r, cnt_inc_s, 2'b00};
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Control state, valid bits and registered outputs; everything holds while rdy_in is low.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r       <= IDLE;
      cnt_r         <= 2'd0;
      base_r        <= 28'd0;
      valid_r       <= {LINES{1'b0}};
      ic_to_iu_rdy  <= 1'b0;
      ic_to_iu_inst <= 32'd0;
      ic_to_mc_req  <= 1'b0;
      ic_to_mc_addr <= 32'd0;
    end else if (rdy_in) begin
      state_r       <= state_s;
      cnt_r         <= cnt_s;
      base_r        <= base_s;
      ic_to_iu_rdy  <= rdy_s;
      ic_to_iu_inst <= inst_s;
      ic_to_mc_req  <= req_s;
      ic_to_mc_addr <= addr_s;
      if (fill_s) begin
        valid_r[fill_idx_s] <= 1'b1;
      end
    end
  end

  // Tag/data arrays and the line buffer carry no reset; only valid bits matter.
  always_ff @(posedge clk_in) begin
    if (rdy_in) begin
      if (buf_we_s) begin
        buf_r[cnt_r] <= mc_to_ic_data;
      end
      if (fill_s) begin
        tag_r[fill_idx_s]     <= base_r[31:INDEX_WIDTH+4];
        data_r[fill_idx_s][0] <= buf_r[0];
        data_r[fill_idx_s][1] <= buf_r[1];
        data_r[fill_idx_s][2] <= buf_r[2];
        data_r[fill_idx_s][3] <= mc_to_ic_data;
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: a latency-programmable memory responder plus
// scoreboards for requested addresses and delivered instruction words.
module tb_icache;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        clr_in;
  logic [31:0] iu_to_ic_pc;
  logic        ic_to_iu_rdy;
  logic [31:0] ic_to_iu_inst;
  logic        ic_to_mc_req;
  logic [31:0] ic_to_mc_addr;
  logic        mc_to_ic_rdy;
  logic [31:0] mc_to_ic_data;

  int errs = 0;
  int checks = 0;
  int mem_lat = 1;
  logic rdy_seen = 1'b1;
  logic [31:0] drv_addr = 32'd0;
  int wcnt = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_inst[$];

  icache #(.INDEX_WIDTH(4)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
    .iu_to_ic_pc(iu_to_ic_pc),
    .ic_to_iu_rdy(ic_to_iu_rdy), .ic_to_iu_inst(ic_to_iu_inst),
    .ic_to_mc_req(ic_to_mc_req), .ic_to_mc_addr(ic_to_mc_addr),
    .mc_to_ic_rdy(mc_to_ic_rdy), .mc_to_ic_data(mc_to_ic_data)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a[31:4] == 28'h0000010) return 32'h11 * ({30'd0, a[3:2]} + 32'd1);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Whether the DUT actually sampled the last edge's inputs.
  always @(posedge clk_in) rdy_seen <= rdy_in;

  // Memory controller model: mem_lat cycles per word, checks each consumed address.
  always @(negedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      mc_to_ic_rdy = 1'b0;
      wcnt = 0;
    end else begin
      if (mc_to_ic_rdy && rdy_seen) begin
        if (exp_addr.size() == 0) chk("unexpected_req", drv_addr, 32'hFFFF_FFFF);
        else chk("req_addr", drv_addr, exp_addr.pop_front());
        mc_to_ic_rdy = 1'b0;
        wcnt = 0;
      end
      if (ic_to_mc_req && !mc_to_ic_rdy && rdy_seen) begin
        wcnt++;
        if (wcnt >= mem_lat) begin
          mc_to_ic_rdy  = 1'b1;
          drv_addr      = ic_to_mc_addr;
          mc_to_ic_data = mem_word(ic_to_mc_addr);
        end
      end
    end
  end

  task automatic push_line(input logic [31:0] base);
    for (int i = 0; i < 4; i++) exp_addr.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_rdy(input string tag, input int maxc, output int cyc);
    cyc = 0;
    while (cyc < maxc) begin
      @(negedge clk_in);
      cyc++;
      if (ic_to_iu_rdy === 1'b1) break;
    end
    if (ic_to_iu_rdy !== 1'b1) begin
      chk({tag, "_timeout"}, 32'(ic_to_iu_rdy), 32'd1);
      cyc = -1;
    end else if (exp_inst.size() == 0) begin
      chk({tag, "_unexpected"}, ic_to_iu_inst, 32'hFFFF_FFFF);
    end else begin
      chk(tag, ic_to_iu_inst, exp_inst.pop_front());
    end
  endtask

  task automatic fetch(input string tag, input logic [31:0] pc, input int exp_cyc);
    int cyc;
    exp_inst.push_back(mem_word(pc));
    iu_to_ic_pc = pc;
    wait_rdy(tag, 60, cyc);
    chk({tag, "_latency"}, 32'(cyc), 32'(exp_cyc));
  endtask

  initial begin
    int cyc;
    logic        held_req;
    logic [31:0] held_addr;
    rst_in = 1'b0; rdy_in = 1'b1; clr_in = 1'b0;
    iu_to_ic_pc = 32'd0; mc_to_ic_data = 32'd0;
    repeat (3) @(posedge clk_in);
    #1;
    chk("rst_rdy", 32'(ic_to_iu_rdy), 32'd0);
    chk("rst_inst", ic_to_iu_inst, 32'd0);
    chk("rst_req", 32'(ic_to_mc_req), 32'd0);
    chk("rst_addr", ic_to_mc_addr, 32'd0);

    // Scenario 1: cold miss, 1-cycle memory
    @(negedge clk_in);
    rst_in = 1'b1;
    push_line(32'h100);
    fetch("s1_miss", 32'h100, 6);

    // Scenario 2: hits on the filled line, PC held keeps rdy high
    fetch("s2_hit_10c", 32'h10C, 1);
    chk("s2_no_req", 32'(ic_to_mc_req), 32'd0);
    exp_inst.push_back(32'h44);
    wait_rdy("s2_hold", 1, cyc);
    fetch("s2_hit_104", 32'h104, 1);

    // Scenario 3: conflict eviction on index 0
    push_line(32'h200);
    fetch("s3_evict", 32'h200, 6);
    push_line(32'h100);
    fetch("s3_refetch", 32'h100, 6);

    // Scenario 4: 3-cycle memory with enable dropped mid-fill
    mem_lat = 3;
    push_line(32'h340);
    exp_inst.push_back(mem_word(32'h348));
    iu_to_ic_pc = 32'h348;
    repeat (5) @(negedge clk_in);
    rdy_in = 1'b0;
    held_req = ic_to_mc_req;
    held_addr = ic_to_mc_addr;
    repeat (2) @(negedge clk_in);
    chk("s4_req_hold", 32'(ic_to_mc_req), 32'(held_req));
    chk("s4_addr_hold", ic_to_mc_addr, held_addr);
    rdy_in = 1'b1;
    wait_rdy("s4_slow", 60, cyc);
    mem_lat = 1;
    fetch("s4_w0", 32'h340, 1);
    fetch("s4_w1", 32'h344, 1);
    fetch("s4_w3", 32'h34C, 1);
    chk("s4_addr_q_empty", 32'(exp_addr.size()), 32'd0);

    // Scenario 5: flush on a hit, then flush during a refill
    iu_to_ic_pc = 32'h100;
    clr_in = 1'b1;
    @(negedge clk_in);
    chk("s5_clr_hit", 32'(ic_to_iu_rdy), 32'd0);
    clr_in = 1'b0;
    exp_inst.push_back(32'h11);
    wait_rdy("s5_after_clr", 1, cyc);
    push_line(32'h400);
    exp_inst.push_back(mem_word(32'h400));
    iu_to_ic_pc = 32'h400;
    @(negedge clk_in);
    chk("s5_fetch_req", 32'(ic_to_mc_req), 32'd1);
    clr_in = 1'b1;
    @(negedge clk_in);
    clr_in = 1'b0;
    wait_rdy("s5_clr_fill", 20, cyc);
    chk("s5_clr_fill_latency", 32'(cyc), 32'd4);
    fetch("s5_rehit", 32'h400, 1);

    // Scenario 6: asynchronous reset after the 2nd word of a refill
    exp_addr.push_back(32'h500);
    exp_addr.push_back(32'h504);
    iu_to_ic_pc = 32'h500;
    cyc = 0;
    while (ic_to_mc_addr !== 32'h508 && cyc < 20) begin
      @(negedge clk_in);
      cyc++;
    end
    chk("s6_reach_w2", ic_to_mc_addr, 32'h508);
    #2 rst_in = 1'b0;
    #1;
    chk("s6_rst_req", 32'(ic_to_mc_req), 32'd0);
    chk("s6_rst_addr", ic_to_mc_addr, 32'd0);
    chk("s6_rst_rdy", 32'(ic_to_iu_rdy), 32'd0);
    @(negedge clk_in);
    rst_in = 1'b1;
    push_line(32'h500);
    fetch("s6_refetch", 32'h500, 6);
    push_line(32'h100);
    fetch("s6_valid_cleared", 32'h100, 6);
    chk("end_addr_q_empty", 32'(exp_addr.size()), 32'd0);
    chk("end_inst_q_empty", 32'(exp_inst.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

endmodule
